execute_unit: RTL
=================

Name: execute_unit

Overview:
- Execute stage directly downstream of the fetch/program-counter stage.
- Consumes one 16-bit instruction per cycle and executes it against a 4 x 16-bit register file.
- Supported operations: load-immediate, ALU operations, an iterative multiply, OUT and HALT.
- Drives stall back to the fetch stage while a multi-cycle multiply runs or after HALT.

Parameters:
- DATA_W, 16: register, ALU and output data width; instruction width is fixed at 16.
- MUL_ITERS, 16: number of shift-add iterations for MUL; must equal DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- instr_valid  in  1  instr is meaningful this cycle
- instr  in  16  instruction word from fetch
- stall  out  1  fetch must hold instr/instr_valid stable while high
- out_data  out  DATA_W  value written by OUT
- out_valid  out  1  one-cycle strobe accompanying out_data
- zero  out  1  last register write produced 0
- halted  out  1  HALT executed; sticky until reset
- illegal  out  1  undefined opcode seen; sticky until reset

Behaviour:
- Reset (already decided): reset rst, synchronous, active-low; clock clk.
  - Registers r0..r3 = 0; out_data = 0; out_valid = 0; zero = 0; halted = 0; illegal = 0.
  - State = IDLE, so stall = 0.
  - Reset wins over every other event; reset during MUL aborts it with no write.
- Instruction format:
  - [15:12] opcode; [11:10] rd; [9:8] rs; [7:0] imm8.
  - instr == 16'h0000 is NOP.
- Accept rule: an instruction is accepted when instr_valid && !stall; otherwise nothing changes.
- Opcodes (results truncated to DATA_W; shift amount is imm8[3:0]):
  - 0x0 NOP.
  - 0x1 LDI: rd <= zero-extended imm8.
  - 0x2 ADD: rd <= rd + rs.
  - 0x3 SUB: rd <= rd - rs (two's-complement wrap).
  - 0x4 AND, 0x5 OR, 0x6 XOR: rd <= rd op rs.
  - 0x7 SHL: rd <= rd << imm8[3:0]; 0x8 SHR: logical shift right by imm8[3:0].
  - 0x9 MUL: rd <= low DATA_W bits of rd*rs.
  - 0xA OUT: out_data <= rd; out_valid = 1.
  - 0xF: HALT only if instr == 16'hFFFF exactly.
  - 0xB-0xE, and 0xF with any other bits: behave as NOP and set illegal.
- Latency:
  - Single-cycle ops accepted in cycle N write rd at the edge ending N; the result is readable by the instruction in N+1 (no hazard).
  - OUT: out_valid high during N+1 only; out_data holds its value until the next OUT.
- zero: updated on every register write (LDI, ALU ops, MUL completion) to (result == 0); unchanged otherwise.
- States: IDLE, MUL, HALTED. stall = (state != IDLE).
- IDLE -> MUL when MUL is accepted:
  - Latch multiplicand = rd, multiplier = rs, acc = 0, iter = 0, destination index.
- MUL state:
  - Each cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; iter++.
  - After MUL_ITERS iterations: write rd = acc, update zero, return to IDLE.
  - MUL accepted in N: stall high N+1..N+16; result visible and stall low in N+17.
  - rd == rs is legal (squares the value).
- IDLE -> HALTED when HALT is accepted:
  - halted = 1 from N+1.
  - stall stays high; all further input is ignored until reset.
- instr_valid low: no state change. out_valid still deasserts after its one-cycle strobe.

Decomposition:
- Shared package: opcode localparams (OP_NOP..OP_OUT, OP_HALT), HALT_WORD = 16'hFFFF, and field bit positions; reused by the assembler and the fetch stage.
- One sub-module: mul_shift_add (start, operands, busy, done, product), owning the iteration counter and the acc/multiplicand/multiplier registers.
- Register file, decode and the FSM stay in execute_unit.

Test Plan:
- After reset, LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0 -> out_valid one cycle with out_data = 8; zero = 0; stall never high.
- LDI r2,7; SUB r2,r2 -> r2 = 0, zero = 1. Then LDI r3,0; SUB r3,r1 with r1 = 1 -> wraps to 16'hFFFF.
- LDI r0,200; LDI r1,300 via SHL sequence; MUL r0,r1 -> stall high exactly 16 cycles; next instruction held until stall drops; OUT r0 gives (r0*r1) mod 2^16.
- Assert rst low at the 8th MUL cycle -> all registers 0, stall 0, no product write, illegal/halted 0.
- Send 16'hB123 -> illegal = 1 and registers unchanged. Then 16'hFFFF -> halted = 1 and stall = 1; subsequent LDI has no effect.
- instr_valid low with instr = LDI r0,9 -> r0 unchanged; back-to-back OUTs -> out_valid high on consecutive cycles.

Source files
------------

// File: rtl/execute_unit_pkg.sv
// ---------------------------------------------------------------------------
// execute_unit_pkg
//   Shared definitions for the execute stage: instruction width, opcode
//   encodings, the HALT word, instruction field bit positions and the
//   execute-stage FSM state type. The assembler and fetch stage use the same
//   opcode and field definitions.
// ---------------------------------------------------------------------------
package execute_unit_pkg;

   localparam int INSTR_W = 16;

   // Opcode encodings (instr[15:12])
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_SHR  = 4'h8;
   localparam logic [3:0] OP_MUL  = 4'h9;
   localparam logic [3:0] OP_OUT  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   // HALT is only recognised as this exact word; other 0xF words are illegal.
   localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

   // Instruction field bit positions
   localparam int OPC_MSB   = 15;
   localparam int OPC_LSB   = 12;
   localparam int RD_MSB    = 11;
   localparam int RD_LSB    = 10;
   localparam int RS_MSB    = 9;
   localparam int RS_LSB    = 8;
   localparam int IMM_MSB   = 7;
   localparam int IMM_LSB   = 0;
   localparam int SHAMT_MSB = 3;   // shift amount is imm8[3:0]

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_HALTED
   } state_t;

endpackage

// File: rtl/execute_unit_mul.sv
// ---------------------------------------------------------------------------
// mul_shift_add
//   Iterative shift-add multiplier producing the low DATA_W bits of a*b.
//   A start pulse latches the operands; one iteration runs per cycle for
//   MUL_ITERS cycles. On the final iteration done is high for one cycle and
//   product carries the finished result combinationally, so the caller can
//   write it on that same edge.
//
//   Ports:
//     clk, rst          clock, synchronous active-low reset (aborts a run)
//     start             begin a multiply (ignored while busy)
//     multiplicand_in   first operand
//     multiplier_in     second operand
//     busy              iterations in progress
//     done              final iteration this cycle (product valid)
//     product           low DATA_W bits of the product
// ---------------------------------------------------------------------------
module mul_shift_add
   import execute_unit_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int MUL_ITERS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] multiplicand_in,
   input  logic [DATA_W-1:0] multiplier_in,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = $clog2(MUL_ITERS + 1);

   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] multiplicand;
   logic [DATA_W-1:0] multiplier;
   logic [CNT_W-1:0]  iter;
   logic [DATA_W-1:0] acc_next;

   // NOTE: acc_next gets a default before the conditional update so every
   // path assigns it and no latch is inferred.
   always_comb begin
      acc_next = acc;
      if (multiplier[0]) begin
         acc_next = acc + multiplicand;
      end
   end

   assign done    = busy && (iter == CNT_W'(MUL_ITERS - 1));
   assign product = acc_next;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy         <= 1'b0;
         acc          <= '0;
         multiplicand <= '0;
         multiplier   <= '0;
         iter         <= '0;
      end else if (start && !busy) begin
         busy         <= 1'b1;
         acc          <= '0;
         multiplicand <= multiplicand_in;
         multiplier   <= multiplier_in;
         iter         <= '0;
      end else if (busy) begin
         acc          <= acc_next;
         multiplicand <= multiplicand << 1;
         multiplier   <= multiplier >> 1;
         iter         <= iter + CNT_W'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/execute_unit.sv
// ---------------------------------------------------------------------------
// execute_unit
//   Execute stage behind fetch. Accepts one 16-bit instruction per cycle when
//   instr_valid && !stall and executes it against a 4 x DATA_W register file.
//   Single-cycle ops write rd at the accepting edge; MUL runs in the
//   mul_shift_add sub-module with stall high until it completes; HALT parks
//   the stage with stall high until reset.
//
//   Ports:
//     clk, rst      clock, synchronous active-low reset
//     instr_valid   instr is meaningful this cycle
//     instr         instruction word from fetch
//     stall         fetch must hold instr/instr_valid while high
//     out_data      value written by the last OUT
//     out_valid     one-cycle strobe accompanying a new out_data
//     zero          last register write produced 0
//     halted        HALT executed (sticky until reset)
//     illegal       undefined opcode seen (sticky until reset)
// ---------------------------------------------------------------------------
module execute_unit
   import execute_unit_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int MUL_ITERS = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               stall,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   output logic               zero,
   output logic               halted,
   output logic               illegal
);

   state_t            state;
   logic [DATA_W-1:0] regs [4];
   logic [1:0]        mul_rd;

   // Instruction fields
   logic [3:0]        op;
   logic [1:0]        rd_idx;
   logic [1:0]        rs_idx;
   logic [7:0]        imm;
   logic [3:0]        shamt;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] rs_val;

   // Decode results
   logic [DATA_W-1:0] alu_result;
   logic              alu_wr;
   logic              is_mul;
   logic              is_out;
   logic              is_halt;
   logic              is_illegal;
   logic              accept;

   // Multiplier interface
   logic              mul_start;
   logic              mul_busy;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;

   assign op     = instr[OPC_MSB:OPC_LSB];
   assign rd_idx = instr[RD_MSB:RD_LSB];
   assign rs_idx = instr[RS_MSB:RS_LSB];
   assign imm    = instr[IMM_MSB:IMM_LSB];
   assign shamt  = instr[SHAMT_MSB:IMM_LSB];
   assign rd_val = regs[rd_idx];
   assign rs_val = regs[rs_idx];

   assign stall     = (state != ST_IDLE);
   assign accept    = instr_valid && (state == ST_IDLE);
   assign mul_start = accept && is_mul;

   always_comb begin
      alu_result = '0;
      alu_wr     = 1'b0;
      is_mul     = 1'b0;
      is_out     = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      case (op)
         OP_NOP: ;
         OP_LDI: begin alu_result = DATA_W'(imm);       alu_wr = 1'b1; end
         OP_ADD: begin alu_result = rd_val + rs_val;    alu_wr = 1'b1; end
         OP_SUB: begin alu_result = rd_val - rs_val;    alu_wr = 1'b1; end
         OP_AND: begin alu_result = rd_val & rs_val;    alu_wr = 1'b1; end
         OP_OR:  begin alu_result = rd_val | rs_val;    alu_wr = 1'b1; end
         OP_XOR: begin alu_result = rd_val ^ rs_val;    alu_wr = 1'b1; end
         OP_SHL: begin alu_result = rd_val << shamt;    alu_wr = 1'b1; end
         OP_SHR: begin alu_result = rd_val >> shamt;    alu_wr = 1'b1; end
         OP_MUL: is_mul = 1'b1;
         OP_OUT: is_out = 1'b1;
         OP_HALT: begin
            // Only the all-ones word halts; any other 0xF word is undefined.
            if (instr == HALT_WORD) begin
               is_halt = 1'b1;
            end else begin
               is_illegal = 1'b1;
            end
         end
         default: is_illegal = 1'b1;
      endcase
   end

   mul_shift_add #(
      .DATA_W    (DATA_W),
      .MUL_ITERS (MUL_ITERS)
   ) u_mul (
      .clk             (clk),
      .rst             (rst),
      .start           (mul_start),
      .multiplicand_in (rd_val),
      .multiplier_in   (rs_val),
      .busy            (mul_busy),
      .done            (mul_done),
      .product         (mul_product)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         // NOTE: the register file is architectural state that must read as
         // zero after reset, so it is cleared here; it is small enough to be
         // flops rather than a RAM macro.
         for (int i = 0; i < 4; i++) begin
            regs[i] <= '0;
         end
         mul_rd    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         zero      <= 1'b0;
         halted    <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         // out_valid is a one-cycle strobe; only an accepted OUT re-raises it.
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (alu_wr) begin
                     regs[rd_idx] <= alu_result;
                     zero         <= (alu_result == '0);
                  end
                  if (is_out) begin
                     out_data  <= rd_val;
                     out_valid <= 1'b1;
                  end
                  if (is_mul) begin
                     mul_rd <= rd_idx;
                     state  <= ST_MUL;
                  end
                  if (is_halt) begin
                     halted <= 1'b1;
                     state  <= ST_HALTED;
                  end
                  if (is_illegal) begin
                     illegal <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               // The product is written on the final iteration's edge, so the
               // instruction held by fetch is accepted in the following cycle.
               if (mul_busy && mul_done) begin
                  regs[mul_rd] <= mul_product;
                  zero         <= (mul_product == '0);
                  state        <= ST_IDLE;
               end
            end
            ST_HALTED: ;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
